alu_op_sequencer: RTL and testbench

//  Issue controller for the ALU/shifter/divider/HiLo-mux datapath. Accepts one funct

---
 rtl/alu_funct_pkg.sv | 19 +
 rtl/alu_op_sequencer_if.sv | 21 ++
 rtl/alu_funct_decode.sv | 14 +
 rtl/alu_op_sequencer.sv | 84 ++++++++
 tb/tb_alu_op_sequencer.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/alu_funct_pkg.sv
// alu_funct_pkg: funct codes, bus width and sequencer state encoding shared by the ALU issue path.
package alu_funct_pkg;
    localparam int FUNCT_W = 6;
    localparam logic [FUNCT_W-1:0] F_AND  = 6'b100100;
    localparam logic [FUNCT_W-1:0] F_OR   = 6'b100101;
    localparam logic [FUNCT_W-1:0] F_ADD  = 6'b100000;
    localparam logic [FUNCT_W-1:0] F_SUB  = 6'b100010;
    localparam logic [FUNCT_W-1:0] F_SLT  = 6'b101010;
    localparam logic [FUNCT_W-1:0] F_SLL  = 6'b000000;
    localparam logic [FUNCT_W-1:0] F_MFHI = 6'b010000;
    localparam logic [FUNCT_W-1:0] F_MFLO = 6'b010010;
    localparam logic [FUNCT_W-1:0] F_DIVU = 6'b011011;
    localparam logic [FUNCT_W-1:0] F_OUT  = 6'b111111;
    localparam logic [FUNCT_W-1:0] F_NOP  = 6'b111110;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_EXEC    = 2'd1;
    localparam logic [1:0] S_DIV_RUN = 2'd2;
    localparam logic [1:0] S_DIV_WB  = 2'd3;
endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: op request handshake plus the shared control bus and status pulses.
interface alu_op_sequencer_if;
    import alu_funct_pkg::*;
    logic               op_valid;
    logic [FUNCT_W-1:0] op_funct;
    logic               op_ready;
    logic [FUNCT_W-1:0] ctrl_funct;
    logic               div_start;
    logic               hilo_we;
    logic               res_valid;
    logic               op_err;
    logic               busy;
    modport master (
        output op_valid, op_funct,
        input  op_ready, ctrl_funct, div_start, hilo_we, res_valid, op_err, busy
    );
    modport slave (
        input  op_valid, op_funct,
        output op_ready, ctrl_funct, div_start, hilo_we, res_valid, op_err, busy
    );
endinterface

// File: rtl/alu_funct_decode.sv
// alu_funct_decode: classifies a requested funct code as single-cycle, divide or illegal.
module alu_funct_decode
    import alu_funct_pkg::*;
(
    input  logic [FUNCT_W-1:0] funct,
    output logic               is_single,
    output logic               is_div,
    output logic               is_illegal
);
    // OUT and NOP are internal bus codes, so they fall through to illegal here.
    assign is_single  = funct inside {F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SLL, F_MFHI, F_MFLO};
    assign is_div     = funct == F_DIVU;
    assign is_illegal = !(is_single || is_div);
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one funct per handshake onto the control bus and sequences
// the multicycle DIVU followed by its HiLo write-back cycle.
module alu_op_sequencer
    import alu_funct_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input logic               clk,
    input logic               rst,
    alu_op_sequencer_if.slave bus
);
    localparam int CW = $clog2(DIV_CYCLES + 1);
    logic [1:0]         state, state_d;
    logic [CW-1:0]      cnt, cnt_d;
    logic [FUNCT_W-1:0] ctrl_d;
    logic               ds_d, we_d, rv_d, err_d;
    logic               is_single, is_div, is_illegal;
    logic               accept;
    alu_funct_decode u_dec (
        .funct      (bus.op_funct),
        .is_single  (is_single),
        .is_div     (is_div),
        .is_illegal (is_illegal)
    );
    assign bus.op_ready = (state == S_IDLE) || (state == S_EXEC);
    assign accept       = bus.op_valid && bus.op_ready;
    // DIV_WB and an idle request both fall through to the IDLE/NOP defaults.
    always_comb begin
        state_d = S_IDLE;
        cnt_d   = '0;
        ctrl_d  = F_NOP;
        ds_d    = 1'b0;
        we_d    = 1'b0;
        rv_d    = 1'b0;
        err_d   = 1'b0;
        if (state == S_DIV_RUN) begin
            if (cnt == CW'(DIV_CYCLES)) begin
                state_d = S_DIV_WB;
                cnt_d   = cnt;
                ctrl_d  = F_OUT;
                we_d    = 1'b1;
                rv_d    = 1'b1;
            end else begin
                state_d = S_DIV_RUN;
                cnt_d   = cnt + CW'(1);
                ctrl_d  = F_DIVU;
            end
        end else if (accept) begin
            if (is_div) begin
                state_d = S_DIV_RUN;
                cnt_d   = CW'(1);
                ctrl_d  = F_DIVU;
                ds_d    = 1'b1;
            end else if (is_single) begin
                state_d = S_EXEC;
                ctrl_d  = bus.op_funct;
                rv_d    = 1'b1;
            end else if (is_illegal) begin
                err_d   = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            bus.ctrl_funct <= F_NOP;
            bus.div_start  <= 1'b0;
            bus.hilo_we    <= 1'b0;
            bus.res_valid  <= 1'b0;
            bus.op_err     <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            bus.ctrl_funct <= ctrl_d;
            bus.div_start  <= ds_d;
            bus.hilo_we    <= we_d;
            bus.res_valid  <= rv_d;
            bus.op_err     <= err_d;
            bus.busy       <= state_d != S_IDLE;
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: timeline model of two builds (DIV_CYCLES 32 and 1) fed the same stimulus.
module tb_alu_op_sequencer;
    localparam int MAXC = 1024;
    localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010, SLL = 6'b000000;
    localparam logic [5:0] MFHI = 6'b010000, DIVU = 6'b011011, OUT = 6'b111111, NOP = 6'b111110;
    typedef struct packed {
        logic [5:0] f;
        logic       ds;
        logic       we;
        logic       rv;
        logic       err;
    } exp_t;
    localparam exp_t IDLE_E = '{f: NOP, ds: 1'b0, we: 1'b0, rv: 1'b0, err: 1'b0};
    logic       clk, rst, op_valid;
    logic [5:0] op_funct;
    logic       s_rst, s_valid;
    logic [5:0] s_funct;
    logic [5:0] ctrl_mon [2];
    logic       ready_mon [2], ds_mon [2], we_mon [2], rv_mon [2], err_mon [2], busy_mon [2];
    int         n_tests = 0, n_fail = 0;
    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s[build%0d]: got %0h expected %0h", nm, g, act, expv);
        end
    endtask
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) begin
        s_rst   <= rst;
        s_valid <= op_valid;
        s_funct <= op_funct;
    end
    for (genvar g = 0; g < 2; g++) begin : u
        localparam int D = (g == 0) ? 32 : 1;
        alu_op_sequencer_if bus ();
        alu_op_sequencer #(.DIV_CYCLES(D)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
        assign bus.op_valid = op_valid;
        assign bus.op_funct = op_funct;
        assign ctrl_mon[g]  = bus.ctrl_funct;
        assign ready_mon[g] = bus.op_ready;
        assign ds_mon[g]    = bus.div_start;
        assign we_mon[g]    = bus.hilo_we;
        assign rv_mon[g]    = bus.res_valid;
        assign err_mon[g]   = bus.op_err;
        assign busy_mon[g]  = bus.busy;
        // Each accepted op books its future bus cycles; blocked is the last cycle with op_ready low.
        initial begin : model
            exp_t  sched [MAXC];
            exp_t  e;
            int    blocked, n;
            logic [10:0] act, expv;
            blocked = -1;
            n = 0;
            for (int i = 0; i < MAXC; i++) sched[i] = IDLE_E;
            forever begin
                @(negedge clk);
                n++;
                if (s_rst) begin
                    for (int i = n; i < MAXC; i++) sched[i] = IDLE_E;
                    blocked = n - 1;
                end else if (s_valid && (n - 1 > blocked)) begin
                    if (s_funct inside {6'b100100, 6'b100101, 6'b100000, 6'b100010,
                                        6'b101010, 6'b000000, 6'b010000, 6'b010010}) begin
                        sched[n] = '{f: s_funct, ds: 1'b0, we: 1'b0, rv: 1'b1, err: 1'b0};
                    end else if (s_funct == DIVU) begin
                        for (int k = 0; k < D; k++)
                            sched[n + k] = '{f: DIVU, ds: k == 0, we: 1'b0, rv: 1'b0, err: 1'b0};
                        sched[n + D] = '{f: OUT, ds: 1'b0, we: 1'b1, rv: 1'b1, err: 1'b0};
                        blocked = n + D;
                    end else begin
                        sched[n] = '{f: NOP, ds: 1'b0, we: 1'b0, rv: 1'b0, err: 1'b1};
                    end
                end
                e    = sched[n];
                act  = {ctrl_mon[g], ds_mon[g], we_mon[g], rv_mon[g], err_mon[g], busy_mon[g], ready_mon[g]};
                expv = {e, e.f != NOP, n > blocked};
                chk($sformatf("cycle%0d", n), g, 32'(act), 32'(expv));
            end
        end
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    initial begin
        int divu, dsn, rlow, out_at, mf_at;
        rst = 1'b1;
        op_valid = 1'b0;
        op_funct = ADD;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", 0, 32'(ctrl_mon[0]), 32'(6'b111110));
        chk("rst_flags", 0, 32'({ds_mon[0], we_mon[0], rv_mon[0], err_mon[0], busy_mon[0], ready_mon[0]}), 32'(6'b000001));
        rst = 1'b0;
        // back-to-back single-cycle ops
        op_valid = 1'b1;
        op_funct = ADD;
        step();
        chk("b2b_add", 0, 32'({ctrl_mon[0], rv_mon[0], ready_mon[0]}), 32'({6'b100000, 2'b11}));
        op_funct = SUB;
        step();
        chk("b2b_sub", 0, 32'({ctrl_mon[0], rv_mon[0], ready_mon[0]}), 32'({6'b100010, 2'b11}));
        op_funct = SLL;
        step();
        chk("b2b_sll", 0, 32'({ctrl_mon[0], rv_mon[0], ready_mon[0]}), 32'({6'b000000, 2'b11}));
        op_valid = 1'b0;
        step();
        // DIVU with MFHI queued behind it; op_funct wanders while op_ready is low
        op_valid = 1'b1;
        op_funct = DIVU;
        step();
        divu = 0; dsn = 0; rlow = 0; out_at = -1; mf_at = -1;
        for (int i = 0; i < 100; i++) begin
            if (ctrl_mon[0] == MFHI) begin
                mf_at = i;
                break;
            end
            divu += int'(ctrl_mon[0] == DIVU);
            dsn  += int'(ds_mon[0]);
            rlow += int'(!ready_mon[0]);
            if (ctrl_mon[0] == OUT && we_mon[0] && rv_mon[0]) out_at = i;
            op_funct = (i < 30) ? 6'b000001 : MFHI;
            step();
        end
        op_valid = 1'b0;
        chk("div_cycles", 0, 32'(divu), 32'd32);
        chk("div_start_pulses", 0, 32'(dsn), 32'd1);
        chk("ready_low_cycles", 0, 32'(rlow), 32'd33);
        chk("out_cycle", 0, 32'(out_at), 32'd32);
        chk("mfhi_cycle", 0, 32'(mf_at), 32'd34);
        step();
        // illegal codes
        op_valid = 1'b1;
        op_funct = 6'b111111;
        step();
        chk("illegal_out", 0, 32'({ctrl_mon[0], err_mon[0], rv_mon[0]}), 32'({6'b111110, 2'b10}));
        op_funct = 6'b000001;
        step();
        chk("illegal_01", 0, 32'({ctrl_mon[0], err_mon[0], rv_mon[0]}), 32'({6'b111110, 2'b10}));
        op_valid = 1'b0;
        step();
        chk("err_clears", 0, 32'(err_mon[0]), 32'd0);
        // reset during DIVU cycle 17, then a fresh ADD
        op_valid = 1'b1;
        op_funct = DIVU;
        step();
        op_valid = 1'b0;
        repeat (16) step();
        chk("div_cycle17", 0, 32'(ctrl_mon[0]), 32'(6'b011011));
        rst = 1'b1;
        step();
        chk("rst_mid_div", 0, 32'({ctrl_mon[0], we_mon[0], rv_mon[0], busy_mon[0], ready_mon[0]}), 32'({6'b111110, 4'b0001}));
        rst = 1'b0;
        op_valid = 1'b1;
        op_funct = ADD;
        step();
        chk("add_after_rst", 0, 32'({ctrl_mon[0], rv_mon[0]}), 32'({6'b100000, 1'b1}));
        // reset beats a simultaneous accept
        rst = 1'b1;
        op_funct = SUB;
        step();
        chk("rst_wins", 0, 32'({ctrl_mon[0], rv_mon[0]}), 32'({6'b111110, 1'b0}));
        rst = 1'b0;
        op_valid = 1'b0;
        step();
        // DIV_CYCLES=1 build
        op_valid = 1'b1;
        op_funct = DIVU;
        step();
        op_valid = 1'b0;
        chk("d1_divu", 1, 32'({ctrl_mon[1], ds_mon[1], we_mon[1]}), 32'({6'b011011, 2'b10}));
        step();
        chk("d1_out", 1, 32'({ctrl_mon[1], ds_mon[1], we_mon[1], rv_mon[1]}), 32'({6'b111111, 3'b011}));
        step();
        chk("d1_idle", 1, 32'({ctrl_mon[1], busy_mon[1], ready_mon[1]}), 32'({6'b111110, 2'b01}));
        repeat (40) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
